// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: turns a valid/ready command into one SETUP/ACCESS
// transfer and returns read data plus slave-error or timeout status.
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [APB_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [APB_DATA_WIDTH-1:0] i_req_wdata,
    input  logic                      i_req_write,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                      o_rsp_err,
    output logic                      o_rsp_timeout,
    output logic                      o_busy,
    output logic [APB_ADDR_WIDTH-1:0] o_PADDR,
    output logic [APB_DATA_WIDTH-1:0] o_PWDATA,
    output logic                      o_PWRITE,
    output logic                      o_PSEL,
    output logic                      o_PENABLE,
    input  logic [APB_DATA_WIDTH-1:0] i_PRDATA,
    input  logic                      i_PREADY,
    input  logic                      i_PSLVERR
);

    // The counter only needs to hold up to TIMEOUT_CYCLES-1: the abort fires on the
    // PREADY-low cycle that would push it to the limit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAST_WAIT_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_WAIT = LAST_WAIT_INT[CNT_W-1:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            o_req_ready   <= 1'b1;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
            o_busy        <= 1'b0;
            o_PADDR       <= '0;
            o_PWDATA      <= '0;
            o_PWRITE      <= 1'b0;
            o_PSEL        <= 1'b0;
            o_PENABLE     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        state       <= SETUP;
                        o_PADDR     <= i_req_addr;
                        o_PWDATA    <= i_req_wdata;
                        o_PWRITE    <= i_req_write;
                        o_PSEL      <= 1'b1;
                        o_PENABLE   <= 1'b0;
                        o_req_ready <= 1'b0;
                        o_busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    o_PENABLE <= 1'b1;
                    wait_cnt  <= '0;
                end
                ACCESS: begin
                    // Completion is checked first so a late PREADY beats the timeout.
                    if (i_PREADY) begin
                        state         <= RESP;
                        o_PSEL        <= 1'b0;
                        o_PENABLE     <= 1'b0;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= o_PWRITE ? '0 : i_PRDATA;
                        o_rsp_err     <= i_PSLVERR;
                        o_rsp_timeout <= 1'b0;
                    end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == LAST_WAIT)) begin
                        state         <= RESP;
                        o_PSEL        <= 1'b0;
                        o_PENABLE     <= 1'b0;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= '0;
                        o_rsp_err     <= 1'b0;
                        o_rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state       <= IDLE;
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
